// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-sequencer: latches the fetched opcode, loads the uPC from the
// main or CB flow-index LUT, and walks the micro-op ROM one word per cycle,
// decoding each word into execute / PC-increment / flag-update strobes.
module dzcpu_uop_sequencer #(
   parameter logic [4:0] JCB_OP    = 5'd6,
   parameter logic [7:0] UPC_LIMIT = 8'd255
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [7:0]  iMop,
   input  logic        iMopValid,
   input  logic [7:0]  iFlowIdx,
   input  logic [7:0]  iCbFlowIdx,
   input  logic [12:0] iUop,
   input  logic        iFlagZ,
   input  logic        iStall,
   output logic [7:0]  oUopAddr,
   output logic [7:0]  oMop,
   output logic [4:0]  oOp,
   output logic [4:0]  oOperand,
   output logic        oExec,
   output logic        oPcInc,
   output logic        oFlagsUpdate,
   output logic        oEof,
   output logic        oFault
);

   localparam logic [2:0] FL_OP         = 3'd0;
   localparam logic [2:0] FL_INC        = 3'd1;
   localparam logic [2:0] FL_EOF        = 3'd2;
   localparam logic [2:0] FL_INC_EOF    = 3'd3;
   localparam logic [2:0] FL_EOF_FU     = 3'd4;
   localparam logic [2:0] FL_INC_EOF_FU = 3'd5;
   localparam logic [2:0] FL_INC_EOF_Z  = 3'd6;
   localparam logic [2:0] FL_INC_EOF_NZ = 3'd7;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  upc, upc_nxt;
   logic [7:0]  mop, mop_nxt;
   logic [2:0]  flow;
   logic [4:0]  op;
   logic [4:0]  operand;
   logic        flow_pcinc;
   logic        eof_taken;
   logic        exec, pcinc, flags_upd, eof, fault;

   assign flow    = iUop[12:10];
   assign op      = iUop[9:5];
   assign operand = iUop[4:0];

   // Decode the flow field: which forms bump the PC and which end the flow now.
   always_comb begin
      flow_pcinc = 1'b0;
      eof_taken  = 1'b0;
      case (flow)
         FL_OP:         begin flow_pcinc = 1'b0; eof_taken = 1'b0;    end
         FL_INC:        begin flow_pcinc = 1'b1; eof_taken = 1'b0;    end
         FL_EOF:        begin flow_pcinc = 1'b0; eof_taken = 1'b1;    end
         FL_INC_EOF:    begin flow_pcinc = 1'b1; eof_taken = 1'b1;    end
         FL_EOF_FU:     begin flow_pcinc = 1'b0; eof_taken = 1'b1;    end
         FL_INC_EOF_FU: begin flow_pcinc = 1'b1; eof_taken = 1'b1;    end
         FL_INC_EOF_Z:  begin flow_pcinc = 1'b1; eof_taken = iFlagZ;  end
         FL_INC_EOF_NZ: begin flow_pcinc = 1'b1; eof_taken = ~iFlagZ; end
         default:       begin flow_pcinc = 1'b0; eof_taken = 1'b0;    end
      endcase
   end

   // Next-state and strobe logic; stall outranks runaway, redirect and Z exit.
   always_comb begin
      state_nxt = state;
      upc_nxt   = upc;
      mop_nxt   = mop;
      exec      = 1'b0;
      pcinc     = 1'b0;
      flags_upd = 1'b0;
      eof       = 1'b0;
      fault     = 1'b0;
      case (state)
         FETCH: begin
            if (iMopValid) begin
               mop_nxt   = iMop;
               upc_nxt   = iFlowIdx;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (!iStall) begin
               if ((upc == UPC_LIMIT) && !eof_taken) begin
                  fault     = 1'b1;
                  state_nxt = FETCH;
               end else if (op == JCB_OP) begin
                  // Without a CB byte on the bus the redirect waits like a stall.
                  if (iMopValid) begin
                     pcinc   = flow_pcinc;
                     upc_nxt = iCbFlowIdx;
                     mop_nxt = iMop;
                  end
               end else begin
                  pcinc     = flow_pcinc;
                  flags_upd = (flow == FL_EOF_FU) || (flow == FL_INC_EOF_FU);
                  eof       = eof_taken;
                  // A taken conditional exit skips the word's operation.
                  exec      = !(eof_taken && (flow == FL_INC_EOF_Z || flow == FL_INC_EOF_NZ));
                  if (eof_taken) begin
                     state_nxt = FETCH;
                  end else begin
                     upc_nxt = upc + 8'd1;
                  end
               end
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Registered sequencer state: FSM, uPC and latched opcode.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state <= FETCH;
         upc   <= 8'd0;
         mop   <= 8'd0;
      end else begin
         state <= state_nxt;
         upc   <= upc_nxt;
         mop   <= mop_nxt;
      end
   end

   assign oUopAddr     = upc;
   assign oMop         = mop;
   assign oOp          = exec ? op : 5'd0;
   assign oOperand     = exec ? operand : 5'd0;
   assign oExec        = exec;
   assign oPcInc       = pcinc;
   assign oFlagsUpdate = flags_upd;
   assign oEof         = eof;
   assign oFault       = fault;

endmodule
